// File: rtl/crossbar_pkg.sv
// Shared types and sizing helpers for the crossbar output scheduler.
package crossbar_pkg;

  localparam int unsigned DEFAULT_NUM_PORTS = 4;
  localparam int unsigned DEFAULT_PORT_W    = $clog2(DEFAULT_NUM_PORTS);

  typedef logic [DEFAULT_PORT_W-1:0] port_idx_t;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_BUSY = 1'b1
  } out_state_e;

  // Index width for an n-entry range; never narrower than one bit.
  function automatic int unsigned port_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/crossbar_scheduler_if.sv
// Request/grant bundle between the input FIFOs, the scheduler and the crossbar datapath.
interface crossbar_if
  import crossbar_pkg::*;
#(
  parameter int unsigned NUM_PORTS = DEFAULT_NUM_PORTS
);
  localparam int unsigned PORT_W = port_w(NUM_PORTS);

  logic [NUM_PORTS-1:0]        req_valid_i;
  logic [NUM_PORTS*PORT_W-1:0] req_dest_i;
  logic [NUM_PORTS-1:0]        eop_i;
  logic [NUM_PORTS-1:0]        grant_o;
  logic [NUM_PORTS*PORT_W-1:0] sel_o;
  logic [NUM_PORTS-1:0]        sel_valid_o;
  logic [NUM_PORTS-1:0]        timeout_o;

  modport master (
    output req_valid_i, req_dest_i, eop_i,
    input  grant_o, sel_o, sel_valid_o, timeout_o
  );

  modport slave (
    input  req_valid_i, req_dest_i, eop_i,
    output grant_o, sel_o, sel_valid_o, timeout_o
  );

endinterface

// File: rtl/crossbar_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module rr_arbiter
  import crossbar_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = DEFAULT_NUM_PORTS,
  localparam int unsigned PORT_W    = port_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PORT_W-1:0]    ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [PORT_W-1:0]    idx_o,
  output logic                 any_gnt_o
);

  always_comb begin
    gnt_o     = '0;
    idx_o     = '0;
    any_gnt_o = 1'b0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      int unsigned c;
      c = (32'(ptr_i) + k) % NUM_PORTS;
      if (!any_gnt_o && req_i[PORT_W'(c)]) begin
        any_gnt_o          = 1'b1;
        idx_o              = PORT_W'(c);
        gnt_o[PORT_W'(c)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/crossbar_scheduler.sv
// Frame-granular crossbar allocator: one RR arbiter, FSM and watchdog per output port.
module crossbar_scheduler
  import crossbar_pkg::*;
#(
  parameter int unsigned NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter int unsigned TIMEOUT   = 2048
) (
  input logic       clk_i,
  input logic       rst_i,
  crossbar_if.slave bus
);

  localparam int unsigned PORT_W = port_w(NUM_PORTS);
  localparam int unsigned WDOG_W = port_w(TIMEOUT);

  logic [NUM_PORTS-1:0]        grant_c;
  logic [NUM_PORTS-1:0]        conn_all [NUM_PORTS];
  logic [NUM_PORTS*PORT_W-1:0] sel_flat;
  logic [NUM_PORTS-1:0]        busy;
  logic [NUM_PORTS-1:0]        timeout_flags;

  // An input is granted when any output holds a connection to it.
  always_comb begin
    grant_c = '0;
    for (int unsigned j = 0; j < NUM_PORTS; j++) begin
      grant_c = grant_c | conn_all[j];
    end
  end

  assign bus.grant_o     = grant_c;
  assign bus.sel_o       = sel_flat;
  assign bus.sel_valid_o = busy;
  assign bus.timeout_o   = timeout_flags;

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out
    out_state_e           state_q, state_d;
    logic [PORT_W-1:0]    sel_q, sel_d;
    logic [PORT_W-1:0]    ptr_q, ptr_d;
    logic [WDOG_W-1:0]    wdog_q, wdog_d;
    logic [NUM_PORTS-1:0] conn_q, conn_d;
    logic                 timeout_q, timeout_d;
    logic [NUM_PORTS-1:0] cand;
    logic [NUM_PORTS-1:0] arb_gnt;
    logic [PORT_W-1:0]    arb_idx;
    logic                 arb_any;

    // Candidates: ungranted inputs with a valid head aimed at this output.
    always_comb begin
      cand = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        cand[i] = bus.req_valid_i[i] && !grant_c[i] &&
                  (bus.req_dest_i[i*PORT_W +: PORT_W] == PORT_W'(j));
      end
    end

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
      .req_i     (cand),
      .ptr_i     (ptr_q),
      .gnt_o     (arb_gnt),
      .idx_o     (arb_idx),
      .any_gnt_o (arb_any)
    );

    always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      ptr_d     = ptr_q;
      wdog_d    = wdog_q;
      conn_d    = conn_q;
      timeout_d = 1'b0;
      unique case (state_q)
        OUT_IDLE: begin
          if (arb_any) begin
            state_d = OUT_BUSY;
            sel_d   = arb_idx;
            conn_d  = arb_gnt;
            wdog_d  = '0;
            ptr_d   = (arb_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : arb_idx + PORT_W'(1);
          end
        end
        OUT_BUSY: begin
          // EOP takes priority so a frame ending on the last allowed cycle is not flagged.
          if (bus.eop_i[sel_q]) begin
            state_d = OUT_IDLE;
            conn_d  = '0;
            wdog_d  = '0;
          end else if ((TIMEOUT != 0) && (32'(wdog_q) == TIMEOUT - 32'd1)) begin
            state_d   = OUT_IDLE;
            conn_d    = '0;
            wdog_d    = '0;
            timeout_d = 1'b1;
          end else begin
            wdog_d = wdog_q + WDOG_W'(1);
          end
        end
        default: state_d = OUT_IDLE;
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q   <= OUT_IDLE;
        sel_q     <= '0;
        ptr_q     <= '0;
        wdog_q    <= '0;
        conn_q    <= '0;
        timeout_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        sel_q     <= sel_d;
        ptr_q     <= ptr_d;
        wdog_q    <= wdog_d;
        conn_q    <= conn_d;
        timeout_q <= timeout_d;
      end
    end

    assign conn_all[j]                    = conn_q;
    assign sel_flat[j*PORT_W +: PORT_W]   = sel_q;
    assign busy[j]                        = (state_q == OUT_BUSY);
    assign timeout_flags[j]               = timeout_q;
  end

endmodule
